// File: rtl/pc_fetch_ctrl_if.sv
// Fetch request channel between the PC unit and the instruction memory port.
//   req_valid  : request valid (driven by the PC unit)
//   req_addr   : fetch address (driven by the PC unit)
//   pc_plus_4  : req_addr + 4 (driven by the PC unit)
//   req_ready  : memory accepts the request (driven by the memory side)
interface pc_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] pc_plus_4;
  logic              req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output pc_plus_4,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  pc_plus_4,
    output req_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage PC unit. Owns the PC register, issues valid/ready fetch requests and merges
// prioritised redirects (exception > jr > j > branch). Redirects that cannot be consumed
// while a request is stalled are parked in a pending register.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   stall_in       : front-end stall, suppresses new requests
//   exc_valid      : exception redirect to PC_EXCEPT
//   jr_valid/jr_target                : register jump
//   j_valid/j_pc_plus_4/j_index       : absolute jump
//   br_valid/br_pc/br_imm             : taken branch
//   fetch          : request channel (req_valid, req_addr, pc_plus_4, req_ready)
//   adel_out       : one-cycle pulse when a misaligned target was replaced
//   fetch_cnt      : number of accepted requests (wraps)
module pc_fetch_ctrl #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] PC_INITIAL = 32'hbfc00000,
  parameter logic [ADDR_W-1:0] PC_EXCEPT  = 32'hbfc00380,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_in,
  input  logic                exc_valid,
  input  logic                jr_valid,
  input  logic [ADDR_W-1:0]   jr_target,
  input  logic                j_valid,
  input  logic [ADDR_W-1:0]   j_pc_plus_4,
  input  logic [25:0]         j_index,
  input  logic                br_valid,
  input  logic [ADDR_W-1:0]   br_pc,
  input  logic [ADDR_W-1:0]   br_imm,
  pc_fetch_ctrl_if.master     fetch,
  output logic                adel_out,
  output logic [CNT_W-1:0]    fetch_cnt
);

  typedef enum logic [1:0] {StBoot, StRun, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              adel_q, adel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] br_tgt, j_tgt, win_tgt, redir_addr;
  logic              redir_any, redir_take, misalign;

  // Only part of the sign-extended offset and of the jump's PC+4 feed the targets.
  logic unused_bits;
  assign unused_bits = ^{br_imm[ADDR_W-1:ADDR_W-2], j_pc_plus_4[ADDR_W-5:0]};

  assign br_tgt = br_pc + {br_imm[ADDR_W-3:0], 2'b00};

  always_comb begin
    j_tgt                      = '0;
    j_tgt[27:0]                = {j_index, 2'b00};
    j_tgt[ADDR_W-1:ADDR_W-4]   = j_pc_plus_4[ADDR_W-1:ADDR_W-4];
  end

  always_comb begin
    if (exc_valid)     win_tgt = PC_EXCEPT;
    else if (jr_valid) win_tgt = jr_target;
    else if (j_valid)  win_tgt = j_tgt;
    else               win_tgt = br_tgt;
  end

  assign redir_any  = exc_valid | jr_valid | j_valid | br_valid;
  // With a redirect already parked, later non-exception redirects are wrong-path noise.
  assign redir_take = exc_valid | (redir_any & ~pend_v_q);
  assign misalign   = ~exc_valid & (win_tgt[1:0] != 2'b00);
  assign redir_addr = misalign ? PC_EXCEPT : win_tgt;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    cnt_d       = cnt_q;
    adel_d      = 1'b0;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (fetch.req_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (redir_take) begin
            pc_d     = redir_addr;
            pend_v_d = 1'b0;
            adel_d   = misalign;
          end else if (pend_v_q) begin
            pc_d     = pend_addr_q;
            pend_v_d = 1'b0;
          end else begin
            pc_d = pc_q + ADDR_W'(4);
          end
          if (stall_in) state_d = StHold;
        end else if (redir_take) begin
          // Request is mid-handshake: keep req_addr stable, park the redirect.
          pend_v_d    = 1'b1;
          pend_addr_d = redir_addr;
          adel_d      = misalign;
        end
      end
      StHold: begin
        if (redir_take) begin
          pc_d     = redir_addr;
          pend_v_d = 1'b0;
          adel_d   = misalign;
        end else if (pend_v_q) begin
          pc_d     = pend_addr_q;
          pend_v_d = 1'b0;
        end
        if (!stall_in) state_d = StRun;
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StBoot;
      pc_q        <= PC_INITIAL;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      adel_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      adel_q      <= adel_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fetch.req_valid = (state_q == StRun);
  assign fetch.req_addr  = pc_q;
  assign fetch.pc_plus_4 = pc_q + ADDR_W'(4);
  assign adel_out        = adel_q;
  assign fetch_cnt       = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        exc_valid;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        j_valid;
  logic [31:0] j_pc_plus_4;
  logic [25:0] j_index;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        adel_out;
  logic [3:0]  fetch_cnt;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl_if #(.ADDR_W(32)) fif ();

  pc_fetch_ctrl #(
    .ADDR_W    (32),
    .PC_INITIAL(32'hbfc00000),
    .PC_EXCEPT (32'hbfc00380),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_in   (stall_in),
    .exc_valid  (exc_valid),
    .jr_valid   (jr_valid),
    .jr_target  (jr_target),
    .j_valid    (j_valid),
    .j_pc_plus_4(j_pc_plus_4),
    .j_index    (j_index),
    .br_valid   (br_valid),
    .br_pc      (br_pc),
    .br_imm     (br_imm),
    .fetch      (fif),
    .adel_out   (adel_out),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and checks happen 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] a,
                           input logic [3:0] c, input logic adel);
    check_eq({tag, ".valid"}, {31'd0, fif.req_valid}, {31'd0, v});
    check_eq({tag, ".addr"}, fif.req_addr, a);
    check_eq({tag, ".cnt"}, {28'd0, fetch_cnt}, {28'd0, c});
    check_eq({tag, ".adel"}, {31'd0, adel_out}, {31'd0, adel});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stall_in = 1'b0; exc_valid = 1'b0; jr_valid = 1'b0; jr_target = '0;
    j_valid = 1'b0; j_pc_plus_4 = '0; j_index = '0; br_valid = 1'b0; br_pc = '0; br_imm = '0;
    fif.req_ready = 1'b1;

    // Reset / boot
    repeat (3) tick();
    check_out("reset", 1'b0, 32'hbfc00000, 4'd0, 1'b0);
    check_eq("reset.pc4", fif.pc_plus_4, 32'hbfc00004);
    reset = 1'b1;
    check_eq("boot.valid", {31'd0, fif.req_valid}, 32'd0);
    tick();
    check_out("first", 1'b1, 32'hbfc00000, 4'd0, 1'b0);
    tick(); check_out("seq1", 1'b1, 32'hbfc00004, 4'd1, 1'b0);
    tick(); check_out("seq2", 1'b1, 32'hbfc00008, 4'd2, 1'b0);
    tick(); check_out("seq3", 1'b1, 32'hbfc0000c, 4'd3, 1'b0);
    tick(); check_out("seq4", 1'b1, 32'hbfc00010, 4'd4, 1'b0);

    // Branch under backpressure: bfc00010 + (ffffffff << 2) = bfc0000c, parked as pending
    fif.req_ready = 1'b0; br_valid = 1'b1; br_pc = 32'hbfc00010; br_imm = 32'hffffffff;
    tick(); check_out("bp_hold1", 1'b1, 32'hbfc00010, 4'd4, 1'b0);
    // Wrong-path redirect while pending must be ignored
    br_valid = 1'b0; jr_valid = 1'b1; jr_target = 32'h80000000;
    tick(); check_out("bp_hold2", 1'b1, 32'hbfc00010, 4'd4, 1'b0);
    jr_valid = 1'b0; fif.req_ready = 1'b1;
    tick(); check_out("bp_pend", 1'b1, 32'hbfc0000c, 4'd5, 1'b0);
    tick(); check_out("bp_clear", 1'b1, 32'hbfc00010, 4'd6, 1'b0);

    // Priority collision: exception wins, no adel
    exc_valid = 1'b1; jr_valid = 1'b1; jr_target = 32'h80000000; br_valid = 1'b1;
    tick(); check_out("prio", 1'b1, 32'hbfc00380, 4'd7, 1'b0);
    exc_valid = 1'b0; br_valid = 1'b0;

    // Misaligned JR -> exception vector with a one-cycle adel pulse
    jr_target = 32'h80000002;
    tick(); check_out("mis_jr", 1'b1, 32'hbfc00380, 4'd8, 1'b1);
    jr_valid = 1'b0;
    tick(); check_out("mis_after", 1'b1, 32'hbfc00384, 4'd9, 1'b0);

    // Aligned JR
    jr_valid = 1'b1; jr_target = 32'h80000000;
    tick(); check_out("jr", 1'b1, 32'h80000000, 4'd10, 1'b0);
    jr_valid = 1'b0;

    // Stall with a jump during HOLD: {b, 0, 100<<2} = b0000400
    stall_in = 1'b1;
    tick(); check_out("stall0", 1'b0, 32'h80000004, 4'd11, 1'b0);
    j_valid = 1'b1; j_pc_plus_4 = 32'hbfc00020; j_index = 26'h0000100;
    tick(); check_out("stall1", 1'b0, 32'hb0000400, 4'd11, 1'b0);
    j_valid = 1'b0;
    tick(); check_out("stall2", 1'b0, 32'hb0000400, 4'd11, 1'b0);
    tick(); check_out("stall3", 1'b0, 32'hb0000400, 4'd11, 1'b0);
    stall_in = 1'b0;
    tick(); check_out("unstall", 1'b1, 32'hb0000400, 4'd11, 1'b0);
    tick(); check_out("unstall_acc", 1'b1, 32'hb0000404, 4'd12, 1'b0);

    // Abort mid-handshake with a parked redirect; reset acts without a clock edge
    fif.req_ready = 1'b0; br_valid = 1'b1; br_pc = 32'h80001000; br_imm = 32'h00000010;
    tick(); check_out("abort_pre", 1'b1, 32'hb0000404, 4'd12, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check_out("abort", 1'b0, 32'hbfc00000, 4'd0, 1'b0);
    check_eq("abort.pc4", fif.pc_plus_4, 32'hbfc00004);
    br_valid = 1'b0;
    tick();
    reset = 1'b1; fif.req_ready = 1'b1;
    tick(); check_out("reboot", 1'b1, 32'hbfc00000, 4'd0, 1'b0);

    // 17 accepts on a 4-bit counter wrap to 1; no pending entry survives reset
    tick(); check_out("wrap_first", 1'b1, 32'hbfc00004, 4'd1, 1'b0);
    repeat (16) tick();
    check_out("wrap", 1'b1, 32'hbfc00044, 4'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
